// File: rtl/miriscv_execute_pipe.sv
// Execute-stage pipeline: DEPTH stages of {valid, payload, result}, plus a hold slot for multi-cycle ops.
// Define MIRISCV_EXEC_REG_READY_EN to make in_ready_o independent of out_ready_i.
module miriscv_execute_pipe #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 96,
    parameter int DEPTH     = 2
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       kill_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PAYLOAD_W-1:0]       in_payload_i,
    input  logic [XLEN-1:0]            in_alu_result_i,
    input  logic                       in_mc_req_i,
    output logic                       mc_start_o,
    output logic                       mc_kill_o,
    input  logic                       mc_done_i,
    input  logic [XLEN-1:0]            mc_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PAYLOAD_W-1:0]       out_payload_o,
    output logic [XLEN-1:0]            out_result_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state;
    logic [DEPTH-1:0]     vld_p;
    logic [PAYLOAD_W-1:0] payload_p [DEPTH];
    logic [XLEN-1:0]      result_p  [DEPTH];
    logic [PAYLOAD_W-1:0] hold_payload;
    logic [XLEN-1:0]      hold_result;

    logic [DEPTH-1:0]     can_acc;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 accept;
    logic                 e_valid;
    logic [PAYLOAD_W-1:0] e_payload;
    logic [XLEN-1:0]      e_result;

    // Stage k can take new content iff some stage at or after k is empty, or the sink drains.
    always_comb begin
        can_acc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            can_acc[k] = out_ready_i;
            for (int j = k; j < DEPTH; j++) begin
                if (!vld_p[j]) can_acc[k] = 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(vld_p[k]);
        end
    end

    assign full = &vld_p;

`ifdef MIRISCV_EXEC_REG_READY_EN
    assign in_ready_o = (state == IDLE) & ~full;
`else
    assign in_ready_o = (state == IDLE) & (~full | out_ready_i);
`endif

    assign accept     = in_valid_i & in_ready_o & ~kill_i;
    assign mc_start_o = accept & in_mc_req_i;
    assign mc_kill_o  = kill_i & (state == BUSY);

    // Stage-0 entry source: the input port in IDLE, the hold slot otherwise.
    always_comb begin
        e_valid   = 1'b0;
        e_payload = in_payload_i;
        e_result  = in_alu_result_i;
        case (state)
            IDLE: e_valid = accept & ~in_mc_req_i;
            BUSY: begin
                e_valid   = mc_done_i & can_acc[0];
                e_payload = hold_payload;
                e_result  = mc_result_i;
            end
            DONE: begin
                e_valid   = can_acc[0];
                e_payload = hold_payload;
                e_result  = hold_result;
            end
            default: e_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            vld_p <= '0;
            state <= IDLE;
        end else if (kill_i) begin
            vld_p <= '0;
            state <= IDLE;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (can_acc[k]) vld_p[k] <= vld_p[k-1];
            end
            if (can_acc[0]) vld_p[0] <= e_valid;
            case (state)
                IDLE: if (mc_start_o) state <= BUSY;
                BUSY: if (mc_done_i) state <= can_acc[0] ? IDLE : DONE;
                DONE: if (can_acc[0]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data registers: no reset, qualified by the same advance conditions as the valids.
    always_ff @(posedge clk_i) begin
        for (int k = 1; k < DEPTH; k++) begin
            if (can_acc[k] && vld_p[k-1]) begin
                payload_p[k] <= payload_p[k-1];
                result_p[k]  <= result_p[k-1];
            end
        end
        if (can_acc[0] && e_valid) begin
            payload_p[0] <= e_payload;
            result_p[0]  <= e_result;
        end
        if (mc_start_o) hold_payload <= in_payload_i;
        if (state == BUSY && mc_done_i && !can_acc[0]) hold_result <= mc_result_i;
    end

    assign out_valid_o   = vld_p[DEPTH-1];
    assign out_payload_o = payload_p[DEPTH-1];
    assign out_result_o  = result_p[DEPTH-1];
    assign count_o       = count;

endmodule
